// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between the I-cache
// (line reads) and the D-cache (line reads and write-backs). It runs one
// whole-line transaction at a time and alternates between I and D sides
// whenever both are waiting.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    // I-cache read port
    input  logic              ic_read_req,
    input  logic [ADDR_W-1:0] ic_read_addr,
    output logic              ic_read_ack,
    output logic [LINE_W-1:0] ic_read_data,
    // D-cache read port
    input  logic              dc_read_req,
    input  logic [ADDR_W-1:0] dc_read_addr,
    output logic              dc_read_ack,
    output logic [LINE_W-1:0] dc_read_data,
    // D-cache write-back port
    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_write_ack,
    // memory port
    output logic              mem_enable,
    output logic              mem_rw,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_data_in,
    output logic [LINE_W-1:0] mem_data_out
);

    typedef enum logic [2:0] {IDLE, IC_RD, DC_RD, DC_WR, RESP} state_t;

    state_t state;
    logic   last_grant_dc;
    logic   d_req;
    logic   grant_i;

    // I wins when it is alone, or when D had the previous grant
    always_comb begin
        d_req   = dc_write_req | dc_read_req;
        grant_i = ic_read_req & (~d_req | last_grant_dc);
    end

    // Transaction sequencer: grant in IDLE, hold the memory request until
    // mem_ack, pulse the matching ack for one RESP cycle, then re-arbitrate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant_dc <= 1'b0;
            ic_read_ack   <= 1'b0;
            ic_read_data  <= '0;
            dc_read_ack   <= 1'b0;
            dc_read_data  <= '0;
            dc_write_ack  <= 1'b0;
            mem_enable    <= 1'b0;
            mem_rw        <= 1'b0;
            mem_addr      <= '0;
            mem_data_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state         <= IC_RD;
                        last_grant_dc <= 1'b0;
                        mem_enable    <= 1'b1;
                        mem_rw        <= 1'b0;
                        mem_addr      <= ic_read_addr;
                        mem_data_out  <= '0;
                    end else if (d_req) begin
                        // write-back goes ahead of a pending D read
                        last_grant_dc <= 1'b1;
                        mem_enable    <= 1'b1;
                        if (dc_write_req) begin
                            state        <= DC_WR;
                            mem_rw       <= 1'b1;
                            mem_addr     <= dc_write_addr;
                            mem_data_out <= dc_write_data;
                        end else begin
                            state        <= DC_RD;
                            mem_rw       <= 1'b0;
                            mem_addr     <= dc_read_addr;
                            mem_data_out <= '0;
                        end
                    end
                end
                IC_RD, DC_RD, DC_WR: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_enable <= 1'b0;
                        mem_rw     <= 1'b0;
                        if (state == IC_RD) begin
                            ic_read_ack  <= 1'b1;
                            ic_read_data <= mem_data_in;
                        end else if (state == DC_RD) begin
                            dc_read_ack  <= 1'b1;
                            dc_read_data <= mem_data_in;
                        end else begin
                            dc_write_ack <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // one idle cycle lets the requester drop req before resampling
                    ic_read_ack  <= 1'b0;
                    dc_read_ack  <= 1'b0;
                    dc_write_ack <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_read_req, dc_read_req, dc_write_req;
    logic [AW-1:0] ic_read_addr, dc_read_addr, dc_write_addr;
    logic [LW-1:0] dc_write_data, mem_data_in;
    logic          mem_ack;
    logic          ic_read_ack, dc_read_ack, dc_write_ack;
    logic [LW-1:0] ic_read_data, dc_read_data, mem_data_out;
    logic          mem_enable, mem_rw;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .reset(reset),
        .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
        .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
        .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
        .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
        .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
        .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks which transaction owns memory, whether we're in the reply beat,
    // and who was served last; predicts every registered output.
    typedef enum {M_FREE, M_IRD, M_DRD, M_DWR, M_REPLY} mphase_t;
    mphase_t       m_phase;
    bit            m_served_d;
    logic          e_en, e_rw, e_iack, e_drack, e_dwack;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_dout, e_idata, e_ddata;

    task automatic model_reset();
        m_phase = M_FREE; m_served_d = 0;
        e_en = 0; e_rw = 0; e_iack = 0; e_drack = 0; e_dwack = 0;
        e_addr = '0; e_dout = '0; e_idata = '0; e_ddata = '0;
    endtask

    // advance the model by one clock, using the inputs about to be sampled
    task automatic model_step();
        bit want_i, want_d, pick_i;
        e_iack = 0; e_drack = 0; e_dwack = 0;
        case (m_phase)
            M_REPLY: m_phase = M_FREE;
            M_IRD, M_DRD, M_DWR: if (mem_ack) begin
                e_en = 0; e_rw = 0;
                if (m_phase == M_IRD) begin e_iack = 1; e_idata = mem_data_in; end
                if (m_phase == M_DRD) begin e_drack = 1; e_ddata = mem_data_in; end
                if (m_phase == M_DWR) e_dwack = 1;
                m_phase = M_REPLY;
            end
            default: begin
                want_i = ic_read_req;
                want_d = dc_read_req || dc_write_req;
                pick_i = want_i && want_d ? m_served_d : want_i;
                if (want_i || want_d) begin
                    e_en = 1;
                    m_served_d = !pick_i;
                    if (pick_i) begin
                        m_phase = M_IRD; e_rw = 0; e_addr = ic_read_addr; e_dout = '0;
                    end else if (dc_write_req) begin
                        m_phase = M_DWR; e_rw = 1; e_addr = dc_write_addr; e_dout = dc_write_data;
                    end else begin
                        m_phase = M_DRD; e_rw = 0; e_addr = dc_read_addr; e_dout = '0;
                    end
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("mem_enable", LW'(mem_enable), LW'(e_en));
        chk("mem_rw", LW'(mem_rw), LW'(e_rw));
        chk("mem_addr", LW'(mem_addr), LW'(e_addr));
        chk("mem_data_out", mem_data_out, e_dout);
        chk("ic_read_ack", LW'(ic_read_ack), LW'(e_iack));
        chk("dc_read_ack", LW'(dc_read_ack), LW'(e_drack));
        chk("dc_write_ack", LW'(dc_write_ack), LW'(e_dwack));
        chk("ic_read_data", ic_read_data, e_idata);
        chk("dc_read_data", dc_read_data, e_ddata);
    endtask

    // ---------------- stimulus agents ----------------
    bit            gen_en = 0;   // random new requests / random memory latency
    bit            hold   = 0;   // requesters keep req high after ack
    int            mem_wait = 3;
    logic [LW-1:0] dir_data = '0;

    function automatic logic [LW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit drop_on_ack();
        return !(hold || (gen_en && ($urandom % 4 == 0)));
    endfunction

    task automatic agents();
        if (ic_read_req && ic_read_ack && drop_on_ack()) ic_read_req = 0;
        else if (!ic_read_req && gen_en && ($urandom % 3 == 0)) begin
            ic_read_req = 1; ic_read_addr = $urandom;
        end else if (ic_read_req && mem_enable && (!gen_en || ($urandom % 8 == 0)))
            ic_read_addr = gen_en ? $urandom : 32'hDEAD_BEE0;

        if (dc_read_req && dc_read_ack && drop_on_ack()) dc_read_req = 0;
        else if (!dc_read_req && gen_en && ($urandom % 3 == 0)) begin
            dc_read_req = 1; dc_read_addr = $urandom;
        end

        if (dc_write_req && dc_write_ack && drop_on_ack()) dc_write_req = 0;
        else if (!dc_write_req && gen_en && ($urandom % 4 == 0)) begin
            dc_write_req = 1; dc_write_addr = $urandom; dc_write_data = rnd128();
        end

        if (mem_enable) begin
            if (mem_wait == 0) begin
                mem_ack = 1; mem_data_in = gen_en ? rnd128() : dir_data;
            end else begin
                mem_ack = 0; mem_wait--;
            end
        end else begin
            mem_wait = gen_en ? int'($urandom % 4) : 3;
            mem_ack = gen_en && ($urandom % 10 == 0);
            mem_data_in = rnd128();
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            agents();
            tick();
        end
    endtask

    initial begin
        reset = 1;
        ic_read_req = 0; dc_read_req = 0; dc_write_req = 0;
        ic_read_addr = '0; dc_read_addr = '0; dc_write_addr = '0;
        dc_write_data = '0; mem_ack = 0; mem_data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 0;
        run(3);

        // spurious mem_ack while idle
        mem_ack = 1; tick();
        mem_ack = 0; tick();

        // single I read, address moved while busy
        dir_data = 128'h0123456789ABCDEF0123456789ABCDEF;
        ic_read_req = 1; ic_read_addr = 32'h0000_0040;
        run(12);
        chk("ic_read_data_line", ic_read_data, 128'h0123456789ABCDEF0123456789ABCDEF);

        // write-back
        dc_write_req = 1; dc_write_addr = 32'h0000_1000;
        dc_write_data = {4{32'hA5A5A5A5}};
        run(12);
        chk("dc_read_data_kept", dc_read_data, '0);

        // all three at once, then fairness with held requests
        dir_data = 128'hFEED;
        ic_read_req = 1; ic_read_addr = 32'h0000_0080;
        dc_read_req = 1; dc_read_addr = 32'h0000_2000;
        dc_write_req = 1; dc_write_addr = 32'h0000_3000; dc_write_data = 128'h77;
        run(30);
        hold = 1;
        ic_read_req = 1; dc_read_req = 1;
        run(42);
        hold = 0;
        run(12);

        // reset in the middle of a write-back
        dc_write_req = 1; dc_write_addr = 32'h0000_4000; dc_write_data = 128'h99;
        run(2);
        chk("wr_busy_before_reset", LW'(mem_enable), LW'(1'b1));
        reset = 1;
        #1;
        chk("reset_mem_enable", LW'(mem_enable), '0);
        chk("reset_acks", LW'({ic_read_ack, dc_read_ack, dc_write_ack}), '0);
        model_reset();
        dc_write_req = 0; mem_ack = 0;
        @(negedge clk);
        reset = 0;
        run(8);

        // randomized traffic
        gen_en = 1;
        run(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
